// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle sequencer.
//   state_t       FETCH/DECODE/EXEC/MEM/WAIT_IO/HALT encoding
//   AC_*          arithmetic-unit function select codes
//   OP_*          bit positions of the one-hot opcode vector
//   ctrl_t        bundle of Moore-decoded datapath controls
//   op_count()    number of opcode lines that are high
//   ctrl_for()    Moore control word for a given state and opcode
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEM     = 3'd3,
      ST_WAIT_IO = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   localparam logic [3:0] AC_ADD  = 4'b1000;
   localparam logic [3:0] AC_SUB  = 4'b1001;
   localparam logic [3:0] AC_MOVA = 4'b0100;
   localparam logic [3:0] AC_NONE = 4'b0000;

   localparam int OP_W    = 12;
   localparam int OP_MOVA = 0;
   localparam int OP_MOVB = 1;
   localparam int OP_MOVC = 2;
   localparam int OP_MOVD = 3;
   localparam int OP_ADD  = 4;
   localparam int OP_SUB  = 5;
   localparam int OP_JMP  = 6;
   localparam int OP_JG   = 7;
   localparam int OP_IN1  = 8;
   localparam int OP_OUT1 = 9;
   localparam int OP_MOVI = 10;
   localparam int OP_HALT = 11;

   typedef struct packed {
      logic       ld_pc;
      logic       in_pc;
      logic       s1;
      logic       s2;
      logic       ram_we;
      logic       ram_re;
      logic       ld_ir;
      logic       reg_we;
      logic       au_en;
      logic       g_en;
      logic       in_en;
      logic       out_en;
      logic [3:0] ac;
      logic       s0;
      logic       halted;
   } ctrl_t;

   function automatic logic [3:0] op_count(input logic [OP_W-1:0] op);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < OP_W; i++) begin
         n = n + {3'b000, op[i]};
      end
      return n;
   endfunction

   // Only the state-and-opcode part of the controls; the gf-qualified jump
   // and the handshake-qualified register write are added in the top.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [OP_W-1:0] op);
      ctrl_t c;
      c        = '0;
      c.s0     = 1'b1;
      c.ac     = AC_NONE;
      case (st)
         ST_FETCH: begin
            c.ram_re = 1'b1;
            c.ld_ir  = 1'b1;
            c.in_pc  = 1'b1;
         end
         ST_DECODE: begin
            c.s0 = 1'b1;
         end
         ST_EXEC: begin
            c.reg_we = op[OP_MOVA] | op[OP_ADD] | op[OP_SUB] | op[OP_MOVI] | op[OP_MOVD];
            c.au_en  = op[OP_MOVA] | op[OP_ADD] | op[OP_SUB];
            c.g_en   = op[OP_SUB];
            c.s0     = ~op[OP_MOVD];
            c.ld_pc  = op[OP_JMP];
            if (op[OP_ADD]) begin
               c.ac = AC_ADD;
            end else if (op[OP_SUB]) begin
               c.ac = AC_SUB;
            end else if (op[OP_MOVA]) begin
               c.ac = AC_MOVA;
            end else begin
               c.ac = AC_NONE;
            end
         end
         ST_MEM: begin
            c.s2     = op[OP_MOVB];
            c.ram_we = op[OP_MOVB];
            c.s1     = op[OP_MOVC];
            c.ram_re = op[OP_MOVC];
            c.reg_we = op[OP_MOVC];
         end
         ST_WAIT_IO: begin
            c.in_en  = op[OP_IN1];
            c.out_en = op[OP_OUT1];
            c.au_en  = op[OP_OUT1];
         end
         ST_HALT: begin
            c.halted = 1'b1;
         end
         default: begin
            c.halted = 1'b0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/io_wait_timer.sv
// io_wait_timer: counts cycles spent waiting on an I/O handshake.
//   clk      system clock
//   rst      synchronous active-high reset
//   clr      return the count to zero (takes priority over en)
//   en       count this cycle
//   expired  high in the LIMIT-th counted cycle, i.e. count == LIMIT-1 while en
module io_wait_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [15:0] LAST = 16'(LIMIT - 1);

   logic [15:0] count_r;

   // Wait-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= 16'd0;
      end else if (clr) begin
         count_r <= 16'd0;
      end else if (en) begin
         count_r <= count_r + 16'd1;
      end
   end

   assign expired = (count_r == LAST) & en;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE sequencer for the model machine.
//   clk, rst                     clock, synchronous active-high reset
//   mova..halt                   one-hot opcode lines, valid from DECODE on
//   gf                           G flag, qualifies jg in EXEC
//   in_rdy, out_ack              I/O device handshakes
//   run                          leaves HALT
//   ld_pc..out_en, ac, s0        datapath controls
//   halted, ill_op, io_err       status (ill_op/io_err sticky until rst)
//   instr_cnt                    retired-instruction count, wraps
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int IO_TIMEOUT = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mova,
   input  logic             movb,
   input  logic             movc,
   input  logic             movd,
   input  logic             add,
   input  logic             sub,
   input  logic             jmp,
   input  logic             jg,
   input  logic             in1,
   input  logic             out1,
   input  logic             movi,
   input  logic             halt,
   input  logic             gf,
   input  logic             in_rdy,
   input  logic             out_ack,
   input  logic             run,
   output logic             ld_pc,
   output logic             in_pc,
   output logic             s1,
   output logic             s2,
   output logic             ram_we,
   output logic             ram_re,
   output logic             ld_ir,
   output logic             reg_we,
   output logic             au_en,
   output logic             g_en,
   output logic             in_en,
   output logic             out_en,
   output logic [3:0]       ac,
   output logic             s0,
   output logic             halted,
   output logic             ill_op,
   output logic             io_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [OP_W-1:0]  op_q_r;
   ctrl_t            ctrl_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ill_op_r;
   logic             io_err_r;

   logic [OP_W-1:0]  op_s;
   logic [3:0]       op_pop_s;
   logic             in_wait_s;
   logic             expired_s;
   logic             handshake_s;
   logic             in_done_s;
   logic             gf_jump_s;

   assign op_s = {halt, movi, out1, in1, jg, jmp, sub, add, movd, movc, movb, mova};
   assign op_pop_s = op_count(op_s);

   assign in_wait_s   = (state_r == ST_WAIT_IO);
   assign in_done_s   = in_wait_s & op_q_r[OP_IN1] & in_rdy;
   assign handshake_s = in_done_s | (in_wait_s & op_q_r[OP_OUT1] & out_ack);
   assign gf_jump_s   = (state_r == ST_EXEC) & op_q_r[OP_JG] & gf;

   // The timer restarts whenever the sequencer is outside WAIT_IO, so it is
   // always zero on the first wait cycle.
   io_wait_timer #(
      .LIMIT (IO_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (~in_wait_s),
      .en      (in_wait_s),
      .expired (expired_s)
   );

   // Sequencer: state, latched opcode, next-state controls, sticky flags, retire count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_FETCH;
         op_q_r   <= '0;
         ctrl_r   <= ctrl_for(ST_FETCH, '0);
         cnt_r    <= '0;
         ill_op_r <= 1'b0;
         io_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               state_r <= ST_DECODE;
               ctrl_r  <= ctrl_for(ST_DECODE, op_q_r);
            end
            ST_DECODE: begin
               // Controls for the next state are taken from op_s because
               // op_q_r only holds the new opcode after this edge.
               op_q_r <= op_s;
               if (op_pop_s > 4'd1) begin
                  ill_op_r <= 1'b1;
                  state_r  <= ST_FETCH;
                  ctrl_r   <= ctrl_for(ST_FETCH, op_s);
               end else if (op_pop_s == 4'd0) begin
                  state_r <= ST_FETCH;
                  ctrl_r  <= ctrl_for(ST_FETCH, op_s);
               end else if (op_s[OP_HALT]) begin
                  state_r <= ST_HALT;
                  ctrl_r  <= ctrl_for(ST_HALT, op_s);
               end else if (op_s[OP_MOVB] | op_s[OP_MOVC]) begin
                  state_r <= ST_MEM;
                  ctrl_r  <= ctrl_for(ST_MEM, op_s);
               end else if (op_s[OP_IN1] | op_s[OP_OUT1]) begin
                  state_r <= ST_WAIT_IO;
                  ctrl_r  <= ctrl_for(ST_WAIT_IO, op_s);
               end else begin
                  state_r <= ST_EXEC;
                  ctrl_r  <= ctrl_for(ST_EXEC, op_s);
               end
            end
            ST_EXEC, ST_MEM: begin
               state_r <= ST_FETCH;
               ctrl_r  <= ctrl_for(ST_FETCH, op_q_r);
               cnt_r   <= cnt_r + CNT_ONE;
            end
            ST_WAIT_IO: begin
               // A handshake in the expiry cycle still completes normally.
               if (handshake_s) begin
                  state_r <= ST_FETCH;
                  ctrl_r  <= ctrl_for(ST_FETCH, op_q_r);
                  cnt_r   <= cnt_r + CNT_ONE;
               end else if (expired_s) begin
                  io_err_r <= 1'b1;
                  state_r  <= ST_FETCH;
                  ctrl_r   <= ctrl_for(ST_FETCH, op_q_r);
               end else begin
                  state_r <= ST_WAIT_IO;
                  ctrl_r  <= ctrl_for(ST_WAIT_IO, op_q_r);
               end
            end
            ST_HALT: begin
               if (run) begin
                  state_r <= ST_FETCH;
                  ctrl_r  <= ctrl_for(ST_FETCH, op_q_r);
               end else begin
                  state_r <= ST_HALT;
                  ctrl_r  <= ctrl_for(ST_HALT, op_q_r);
               end
            end
            default: begin
               state_r <= ST_FETCH;
               ctrl_r  <= ctrl_for(ST_FETCH, op_q_r);
            end
         endcase
      end
   end

   // Output pins: registered controls plus the two qualified terms, held idle while rst is high.
   always_comb begin
      ld_pc     = 1'b0;
      in_pc     = 1'b0;
      s1        = 1'b0;
      s2        = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ld_ir     = 1'b0;
      reg_we    = 1'b0;
      au_en     = 1'b0;
      g_en      = 1'b0;
      in_en     = 1'b0;
      out_en    = 1'b0;
      ac        = AC_NONE;
      s0        = 1'b1;
      halted    = 1'b0;
      ill_op    = 1'b0;
      io_err    = 1'b0;
      instr_cnt = '0;
      if (rst) begin
         s0 = 1'b1;
      end else begin
         ld_pc     = ctrl_r.ld_pc | gf_jump_s;
         in_pc     = ctrl_r.in_pc;
         s1        = ctrl_r.s1;
         s2        = ctrl_r.s2;
         ram_we    = ctrl_r.ram_we;
         ram_re    = ctrl_r.ram_re;
         ld_ir     = ctrl_r.ld_ir;
         reg_we    = ctrl_r.reg_we | in_done_s;
         au_en     = ctrl_r.au_en;
         g_en      = ctrl_r.g_en;
         in_en     = ctrl_r.in_en;
         out_en    = ctrl_r.out_en;
         ac        = ctrl_r.ac;
         s0        = ctrl_r.s0;
         halted    = ctrl_r.halted;
         ill_op    = ill_op_r;
         io_err    = io_err_r;
         instr_cnt = cnt_r;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model produces the
// expected output word for every cycle; one compare process checks it at the
// falling edge, plus literal pins of the status outputs at chosen points.
module tb_multicycle_controller;

   localparam int T  = 6;
   localparam int CW = 4;

   localparam int B_MOVA = 0, B_MOVB = 1, B_MOVC = 2, B_MOVD = 3, B_ADD = 4, B_SUB = 5;
   localparam int B_JMP = 6, B_JG = 7, B_IN1 = 8, B_OUT1 = 9, B_MOVI = 10, B_HALT = 11;

   typedef struct packed {
      logic          ld_pc, in_pc, s1, s2, ram_we, ram_re, ld_ir, reg_we;
      logic          au_en, g_en, in_en, out_en;
      logic [3:0]    ac;
      logic          s0, halted, ill_op, io_err;
      logic [CW-1:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [11:0]   op_drv = 12'd0;
   logic          gf = 1'b0, in_rdy = 1'b0, out_ack = 1'b0, run = 1'b0;
   logic          mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt;
   logic          ld_pc, in_pc, s1, s2, ram_we, ram_re, ld_ir, reg_we, au_en, g_en, in_en, out_en;
   logic [3:0]    ac;
   logic          s0, halted, ill_op, io_err;
   logic [CW-1:0] instr_cnt;

   assign {halt, movi, out1, in1, jg, jmp, sub, add, movd, movc, movb, mova} = op_drv;

   multicycle_controller #(.IO_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .mova(mova), .movb(movb), .movc(movc), .movd(movd), .add(add), .sub(sub),
      .jmp(jmp), .jg(jg), .in1(in1), .out1(out1), .movi(movi), .halt(halt),
      .gf(gf), .in_rdy(in_rdy), .out_ack(out_ack), .run(run),
      .ld_pc(ld_pc), .in_pc(in_pc), .s1(s1), .s2(s2), .ram_we(ram_we), .ram_re(ram_re),
      .ld_ir(ld_ir), .reg_we(reg_we), .au_en(au_en), .g_en(g_en), .in_en(in_en),
      .out_en(out_en), .ac(ac), .s0(s0), .halted(halted), .ill_op(ill_op),
      .io_err(io_err), .instr_cnt(instr_cnt)
   );

   obs_t got_s;
   assign got_s = {ld_pc, in_pc, s1, s2, ram_we, ram_re, ld_ir, reg_we, au_en, g_en,
                   in_en, out_en, ac, s0, halted, ill_op, io_err, instr_cnt};

   // Model state and per-cycle expectation (written by the stimulus process only)
   obs_t          exp_r;
   logic          exp_valid = 1'b0;
   logic          m_ill = 1'b0, m_io = 1'b0;
   logic [CW-1:0] m_cnt = '0;
   logic          pin_req = 1'b0, pin_on = 1'b0;
   logic [CW-1:0] pin_req_cnt = '0, pin_cnt = '0;
   logic          pin_req_ill = 1'b0, pin_req_io = 1'b0, pin_ill = 1'b0, pin_io = 1'b0;

   int total = 0;
   int bad   = 0;

   // Compare process: every meaningful cycle, plus literal pins when requested.
   always @(negedge clk) begin
      if (exp_valid) begin
         total++;
         if (got_s !== exp_r) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, got_s, exp_r);
         end
         if (pin_on) begin
            total++;
            if ({instr_cnt, ill_op, io_err} !== {pin_cnt, pin_ill, pin_io}) begin
               bad++;
               $display("FAIL pinned_status t=%0t got cnt=%0d ill=%b io=%b want cnt=%0d ill=%b io=%b",
                        $time, instr_cnt, ill_op, io_err, pin_cnt, pin_ill, pin_io);
            end
         end
      end
   end

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [11:0] rop();
      return 12'($urandom);
   endfunction

   function automatic logic [11:0] onehot(input int idx);
      logic [11:0] v;
      v = 12'd0;
      v[idx[3:0]] = 1'b1;
      return v;
   endfunction

   function automatic obs_t idle();
      obs_t e;
      e = '0;
      e.s0 = 1'b1;
      return e;
   endfunction

   // One normal (rst low) cycle: drive inputs, post expectation.
   task automatic cyc(input obs_t e, input logic [11:0] opv, input logic rdy,
                      input logic ack, input logic rn, input logic g);
      @(posedge clk);
      #1;
      rst = 1'b0; op_drv = opv; in_rdy = rdy; out_ack = ack; run = rn; gf = g;
      e.ill_op = m_ill; e.io_err = m_io; e.cnt = m_cnt;
      exp_r = e;
      exp_valid = 1'b1;
      pin_on = pin_req; pin_cnt = pin_req_cnt; pin_ill = pin_req_ill; pin_io = pin_req_io;
      pin_req = 1'b0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst = 1'b1; op_drv = rop(); in_rdy = rb(); out_ack = rb(); run = rb(); gf = rb();
         exp_r = idle();
         exp_valid = 1'b1;
         pin_on = 1'b0;
      end
      m_cnt = '0; m_ill = 1'b0; m_io = 1'b0;
   endtask

   task automatic pin(input int c, input logic i, input logic o);
      pin_req = 1'b1; pin_req_cnt = CW'(c); pin_req_ill = i; pin_req_io = o;
   endtask

   // Whole instruction: k = wait cycles before handshake (k >= T means none),
   // hold = HALT cycles before the run pulse.
   task automatic run_instr(input logic [11:0] opv, input logic gfv, input int k, input int hold);
      obs_t e;
      int   n;
      logic hs;
      n = $countones(opv);
      e = idle(); e.in_pc = 1'b1; e.ram_re = 1'b1; e.ld_ir = 1'b1;
      cyc(e, rop(), rb(), rb(), rb(), rb());
      cyc(idle(), opv, rb(), rb(), rb(), rb());
      if (n > 1) begin
         m_ill = 1'b1;
         return;
      end
      if (n == 0) return;
      if (opv[B_HALT]) begin
         e = idle(); e.halted = 1'b1;
         for (int i = 0; i < hold; i++) cyc(e, rop(), rb(), rb(), 1'b0, rb());
         cyc(e, rop(), rb(), rb(), 1'b1, rb());
         return;
      end
      if (opv[B_MOVB] || opv[B_MOVC]) begin
         e = idle();
         e.s2 = opv[B_MOVB]; e.ram_we = opv[B_MOVB];
         e.s1 = opv[B_MOVC]; e.ram_re = opv[B_MOVC]; e.reg_we = opv[B_MOVC];
         cyc(e, rop(), rb(), rb(), rb(), rb());
         m_cnt = m_cnt + 1'b1;
         return;
      end
      if (opv[B_IN1] || opv[B_OUT1]) begin
         for (int j = 0; j < T; j++) begin
            hs = (j == k);
            e = idle();
            if (opv[B_IN1]) begin
               e.in_en = 1'b1; e.reg_we = hs;
               cyc(e, rop(), hs, rb(), rb(), rb());
            end else begin
               e.out_en = 1'b1; e.au_en = 1'b1;
               cyc(e, rop(), rb(), hs, rb(), rb());
            end
            if (hs) begin
               m_cnt = m_cnt + 1'b1;
               return;
            end
         end
         m_io = 1'b1;
         return;
      end
      e = idle();
      e.reg_we = opv[B_MOVA] | opv[B_ADD] | opv[B_SUB] | opv[B_MOVI] | opv[B_MOVD];
      e.au_en  = opv[B_MOVA] | opv[B_ADD] | opv[B_SUB];
      e.g_en   = opv[B_SUB];
      e.s0     = ~opv[B_MOVD];
      e.ld_pc  = opv[B_JMP] | (opv[B_JG] & gfv);
      e.ac     = opv[B_ADD] ? 4'b1000 : opv[B_SUB] ? 4'b1001 : opv[B_MOVA] ? 4'b0100 : 4'b0000;
      cyc(e, rop(), rb(), rb(), rb(), gfv);
      m_cnt = m_cnt + 1'b1;
   endtask

   // out1 that is cut off by rst after n wait cycles.
   task automatic abort_out1(input int n);
      obs_t e;
      e = idle(); e.in_pc = 1'b1; e.ram_re = 1'b1; e.ld_ir = 1'b1;
      cyc(e, rop(), rb(), rb(), rb(), rb());
      cyc(idle(), onehot(B_OUT1), rb(), rb(), rb(), rb());
      e = idle(); e.out_en = 1'b1; e.au_en = 1'b1;
      for (int i = 0; i < n; i++) cyc(e, rop(), rb(), 1'b0, rb(), rb());
      do_reset(1);
   endtask

   initial begin
      int r;
      int i1;
      logic [11:0] o;
      do_reset(2);
      run_instr(onehot(B_ADD), 1'b0, 0, 0);
      pin(1, 1'b0, 1'b0);
      run_instr(onehot(B_JG), 1'b0, 0, 0);
      run_instr(onehot(B_JG), 1'b1, 0, 0);
      pin(3, 1'b0, 1'b0);
      run_instr(onehot(B_IN1), 1'b0, 4, 0);
      pin(4, 1'b0, 1'b0);
      run_instr(onehot(B_IN1), 1'b0, T - 1, 0);
      pin(5, 1'b0, 1'b0);
      run_instr(onehot(B_IN1), 1'b0, T, 0);
      pin(5, 1'b0, 1'b1);
      run_instr(onehot(B_ADD) | onehot(B_SUB), 1'b0, 0, 0);
      pin(5, 1'b1, 1'b1);
      run_instr(12'd0, 1'b0, 0, 0);
      pin(5, 1'b1, 1'b1);
      run_instr(onehot(B_HALT), 1'b0, 0, 10);
      pin(5, 1'b1, 1'b1);
      run_instr(onehot(B_OUT1), 1'b0, 0, 0);
      pin(6, 1'b1, 1'b1);
      run_instr(onehot(B_MOVB), 1'b0, 0, 0);
      run_instr(onehot(B_MOVC), 1'b0, 0, 0);
      run_instr(onehot(B_MOVD), 1'b0, 0, 0);
      run_instr(onehot(B_JMP), 1'b0, 0, 0);
      pin(10, 1'b1, 1'b1);
      abort_out1(2);
      pin(0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) run_instr(onehot(B_MOVI), 1'b0, 0, 0);
      pin(15, 1'b0, 1'b0);
      run_instr(onehot(B_MOVI), 1'b0, 0, 0);
      pin(0, 1'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            o = 12'd0;
         end else if (r < 10) begin
            i1 = $urandom_range(0, 11);
            o = onehot(i1) | onehot((i1 + $urandom_range(1, 11)) % 12);
         end else if (r < 13) begin
            o = onehot(B_HALT);
         end else begin
            o = onehot($urandom_range(0, 10));
         end
         if (r == 99) do_reset($urandom_range(1, 2));
         if (r == 98) abort_out1($urandom_range(0, T - 1));
         run_instr(o, rb(), $urandom_range(0, T), $urandom_range(0, 3));
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
